// File: rtl/hilo_muldiv.sv
// ============================================================================
// Module      : hilo_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write
//               port, with pipeline stall request and flush support.
//               Optional build macro MULDIV_FAST_MUL_EN selects a
//               single-cycle multiplier for MULT/MULTU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_o,
  output logic             done,
  output logic             hiwe,
  output logic             lowe,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic                 r_is_div;
  logic                 r_is_signed;
  logic [WIDTH-1:0]     r_src_a;
  logic [WIDTH-1:0]     r_src_b;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_res_hi;
  logic [WIDTH-1:0]     r_res_lo;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_div_zero;
  logic                 w_cnt_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic                 w_accept;

  assign w_accept   = (r_state == S_IDLE) && start && !cancel;
  assign w_abs_a    = (r_is_signed && r_src_a[WIDTH-1]) ? -r_src_a : r_src_a;
  assign w_abs_b    = (r_is_signed && r_src_b[WIDTH-1]) ? -r_src_b : r_src_b;
  assign w_div_zero = r_is_div && (r_src_b == '0);
  assign w_cnt_last = (r_cnt == CNT_W'(1));

  // Multiply: low half of the accumulator holds the multiplier and shifts out
  // as the product shifts in from the top.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: accumulator is {remainder, dividend/quotient}; a borrow restores.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_step = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    busy    = (r_state != S_IDLE);
    stall_o = w_accept || (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
    // A flush landing in DONE suppresses the write.
    done    = (r_state == S_DONE) && !cancel;
    hiwe    = done;
    lowe    = done;
    hi_o    = done ? r_res_hi : r_hi;
    lo_o    = done ? r_res_lo : r_lo;

    case (r_state)
      S_IDLE: if (w_accept) w_next = S_PREP;
      S_PREP: begin
        if (w_div_zero) begin
          w_next = S_DONE;
        end else if (!r_is_div) begin
`ifdef MULDIV_FAST_MUL_EN
          w_next = S_FIX;
`else
          w_next = S_CALC;
`endif
        end else begin
          w_next = S_CALC;
        end
      end
      S_CALC: if (w_cnt_last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    if (cancel && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div    <= op[1];
            r_is_signed <= ~op[0];
            r_src_a     <= src_a;
            r_src_b     <= src_b;
          end
        end
        S_PREP: begin
          r_neg_res <= r_is_signed && (r_src_a[WIDTH-1] ^ r_src_b[WIDTH-1]);
          r_neg_rem <= r_is_signed && r_src_a[WIDTH-1];
          r_cnt     <= CNT_W'(WIDTH);
          // Divide-by-zero result; overwritten in FIX on every other path.
          r_res_hi  <= r_src_a;
          r_res_lo  <= '1;
          if (r_is_div) begin
            r_opnd <= w_abs_b;
            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
          end else begin
            r_opnd <= w_abs_a;
`ifdef MULDIV_FAST_MUL_EN
            r_acc  <= w_fast_prod;
`else
            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
`endif
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_res_hi <= w_rem_fix;
            r_res_lo <= w_quo_fix;
          end else begin
            r_res_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_res_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase

      if (done) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end
  end

endmodule

`default_nettype wire
